// File: rtl/instr_encoder_pkg.sv
// Shared types and encoding constants for the LEGv8 instruction encoder / program loader.
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN (see instr_encoder.sv).
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_LDUR = 2'b00,
    FMT_STUR = 2'b01,
    FMT_CBZ  = 2'b10,
    FMT_RSVD = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FILL = 2'b01,
    S_FULL = 2'b10
  } state_e;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam int IMM_D_W  = 9;
  localparam int IMM_CB_W = 19;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: decoded fields -> 32-bit LEGv8 word, plus format / immediate-range flags.
// Kept standalone so it can sit next to the sign-extend unit for round-trip checks.
module instr_pack
  import instr_encoder_pkg::*;
#(
  parameter int N = 64
) (
  input  fmt_e           fmt,
  input  logic [4:0]     rt,
  input  logic [4:0]     rn,
  input  logic [N-1:0]   imm,
  output logic [31:0]    word,
  output logic           range_ok,
  output logic           fmt_ok
);

  // An immediate fits in K signed bits when every bit from K-1 upward is a copy of the sign.
  logic [N-IMM_D_W:0]  d_hi;
  logic [N-IMM_CB_W:0] cb_hi;
  logic                d_fits;
  logic                cb_fits;

  assign d_hi    = imm[N-1:IMM_D_W-1];
  assign cb_hi   = imm[N-1:IMM_CB_W-1];
  assign d_fits  = (&d_hi) | ~(|d_hi);
  assign cb_fits = (&cb_hi) | ~(|cb_hi);

  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    fmt_ok   = 1'b1;
    case (fmt)
      FMT_LDUR: begin
        word     = {OP_LDUR, imm[IMM_D_W-1:0], 2'b00, rn, rt};
        range_ok = d_fits;
      end
      FMT_STUR: begin
        word     = {OP_STUR, imm[IMM_D_W-1:0], 2'b00, rn, rt};
        range_ok = d_fits;
      end
      FMT_CBZ: begin
        word     = {OP_CBZ, imm[IMM_CB_W-1:0], rt};
        range_ok = cb_fits;
      end
      default: begin
        fmt_ok   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Boot/test program loader: encodes LDUR/STUR/CBZ beats and writes them to IMEM from address 0.
// Define INSTR_ENCODER_RANGE_CHECK_EN to reject out-of-range immediates instead of truncating them.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter  int N          = 64,
  parameter  int IMEM_DEPTH = 64,
  localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [4:0]        rt,
  input  logic [4:0]        rn,
  input  logic [N-1:0]      imm,
  input  logic              flush,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(IMEM_DEPTH - 1);

  state_e              state_reg, state_next;
  logic [ADDR_W:0]     count_reg;
  logic                wr_en_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [31:0]         wr_data_reg;
  logic                err_reg;

  logic [31:0]         packed_word;
  logic                range_ok;
  logic                fmt_ok;
  logic                writable;
  logic                accept;
  logic                do_write;
  logic                do_reject;

  instr_pack #(.N(N)) u_pack (
    .fmt      (fmt_e'(fmt)),
    .rt       (rt),
    .rn       (rn),
    .imm      (imm),
    .word     (packed_word),
    .range_ok (range_ok),
    .fmt_ok   (fmt_ok)
  );

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign writable = fmt_ok && range_ok;
`else
  logic unused_range_ok;
  assign unused_range_ok = range_ok;
  assign writable        = fmt_ok;
`endif

  // Flush overrides a coincident handshake: the beat is dropped, not written.
  assign accept    = in_valid && in_ready && !flush;
  assign do_write  = accept && writable;
  assign do_reject = accept && !writable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else if (do_write) begin
      state_next = (count_reg == LAST_COUNT) ? S_FULL : S_FILL;
    end
  end

  always_comb begin
    in_ready = (state_reg != S_FULL);
    full     = (state_reg == S_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      wr_en_reg <= do_write;
      if (flush) begin
        count_reg <= '0;
        err_reg   <= 1'b0;
      end else begin
        if (do_write) begin
          wr_addr_reg <= count_reg[ADDR_W-1:0];
          wr_data_reg <= packed_word;
          count_reg   <= count_reg + 1'b1;
        end
        if (do_reject) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign count   = count_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios then randomized beats against a field-level model.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    fmt;
  logic [4:0]    rt;
  logic [4:0]    rn;
  logic [N-1:0]  imm;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encoder #(.N(N), .IMEM_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fmt      (fmt),
    .rt       (rt),
    .rn       (rn),
    .imm      (imm),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .full     (full),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  int  m_count = 0;
  bit  m_err   = 0;
  int  n_total = 0;
  int  n_pass  = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic bit ref_in_range(input longint v, input int k);
    longint lim;
    lim = longint'(1) << (k - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic logic [31:0] ref_word(input int f, input int rt_i, input int rn_i, input longint v);
    longint w;
    case (f)
      0:       w = (longint'('h7C2) << 21) | ((v & 'h1FF) << 12) | (longint'(rn_i) << 5) | longint'(rt_i);
      1:       w = (longint'('h7C0) << 21) | ((v & 'h1FF) << 12) | (longint'(rn_i) << 5) | longint'(rt_i);
      default: w = (longint'('hB4) << 24) | ((v & 'h7FFFF) << 5) | longint'(rt_i);
    endcase
    return w[31:0];
  endfunction

  task automatic check_status();
    check("in_ready", in_ready, m_count != DEPTH);
    check("full", full, m_count == DEPTH);
    check("count", count, m_count);
    check("err", err, m_err);
  endtask

  // One cycle: check registered status, drive the beat, and predict its effect at the next edge.
  task automatic beat(input bit v, input int f, input int rt_i, input int rn_i,
                      input longint imm_i, input bit fl, input logic [31:0] exp_w = 32'h0);
    wr_t e;
    bit  ok;
    @(negedge clk);
    check_status();
    in_valid = v;
    fmt      = f[1:0];
    rt       = rt_i[4:0];
    rn       = rn_i[4:0];
    imm      = imm_i;
    flush    = fl;
    if (fl) begin
      m_count = 0;
      m_err   = 0;
    end else if (v && m_count != DEPTH) begin
      ok = (f != 3) && (!RC || ref_in_range(imm_i, (f == 2) ? 19 : 9));
      if (ok) begin
        e.addr = m_count;
        e.data = (exp_w != 32'h0) ? exp_w : ref_word(f, rt_i, rn_i, imm_i);
        q.push_back(e);
        m_count++;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic idle();
    beat(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      check("wr_en", wr_en, q.size() != 0);
      if (wr_en && q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        $display("write addr=%0d data=%08h", wr_addr, wr_data);
      end else if (q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  function automatic longint pick_imm();
    case ($urandom_range(0, 8))
      0: return -256;
      1: return 255;
      2: return 256;
      3: return -257;
      4: return -262144;
      5: return 262143;
      6: return 262144;
      7: return longint'({$urandom, $urandom});
      default: return longint'($urandom_range(0, 600)) - 300;
    endcase
  endfunction

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    fmt      = '0;
    rt       = '0;
    rn       = '0;
    imm      = '0;
    flush    = 1'b0;
    #12;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    #5 reset_n = 1'b1;

    // Basic LDUR
    beat(1, 0, 2, 1, 1, 0, 32'hF8401022);
    idle();
    // STUR then CBZ back-to-back from a fresh pointer
    beat(0, 0, 0, 0, 0, 1);
    beat(1, 1, 2, 1, -2, 0, 32'hF81FE022);
    beat(1, 2, 2, 0, -3, 0, 32'hB4FFFFA2);
    // Out-of-range D-format immediate
    beat(1, 0, 2, 1, 256, 0, RC ? 32'h0 : 32'hF8500022);
    idle();
    // Reserved format, then flush clears err and count
    beat(0, 0, 0, 0, 0, 1);
    beat(1, 3, 2, 1, 0, 0);
    idle();
    beat(0, 0, 0, 0, 0, 1);
    idle();
    // Fill all slots with in_valid held; fifth beat stalls until flush
    for (int i = 0; i < 5; i++) beat(1, 0, i, 3, i, 0);
    beat(1, 0, 4, 3, 4, 1);
    beat(1, 0, 4, 3, 4, 0);
    // Flush coinciding with an accept drops the beat
    beat(1, 1, 7, 8, 9, 1);
    idle();
    // Asynchronous reset while a write is on the bus
    beat(1, 0, 5, 6, 7, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #0.5;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_count", count, 0);
    check("midrst_err", err, 0);
    m_count = 0;
    m_err   = 0;
    q.delete();
    #0.5 reset_n = 1'b1;
    beat(1, 2, 9, 0, 100, 0);
    idle();

    for (int i = 0; i < 300; i++) begin
      beat($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 31),
           $urandom_range(0, 31), pick_imm(), $urandom_range(0, 15) == 0);
    end
    idle();
    idle();
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Inverse of the sign-extend/immediate-extract path.
- Accepts decoded instruction fields (format, registers, full-width signed immediate) over a valid/ready handshake.
- Packs them into 32-bit LEGv8 words (LDUR, STUR, CBZ).
- Writes the words sequentially into instruction memory from address 0. It serves as the processor's test/boot program loader.

## Interface
- `N`, 64: immediate input width.
- `IMEM_DEPTH`, 64: number of instruction words the block may write; `ADDR_W = $clog2(IMEM_DEPTH)`.
- `clk  in  1  ` single clock, rising edge.
- `reset_n  in  1  ` asynchronous, active-low reset.
- `in_valid  in  1  ` beat present.
- `in_ready  out  1  ` block can accept a beat.
- `fmt  in  2  ` 00 LDUR, 01 STUR, 10 CBZ, 11 reserved.
- `rt  in  5  ` Rt field.
- `rn  in  5  ` Rn field (ignored for CBZ).
- `imm  in  N  ` signed immediate (two's complement).
- `flush  in  1  ` synchronous restart: pointer to 0, clear error.
- `wr_en  out  1  ` instruction memory write strobe.
- `wr_addr  out  ADDR_W  ` word address.
- `wr_data  out  32  ` encoded instruction.
- `count  out  ADDR_W+1  ` words written since reset/flush.
- `full  out  1  ` `count == IMEM_DEPTH`.
- `err  out  1  ` sticky: reserved fmt or out-of-range immediate seen.

## Operation
**Encodings:**
- LDUR = `11111000010 | imm[8:0] | 00 | rn | rt`
- STUR = `11111000000 | imm[8:0] | 00 | rn | rt`
- CBZ = `10110100 | imm[18:0] | rt`

**Range check:** imm is in range when `imm[N-1:K-1]` are all equal, with K=9 (D-format) or K=19 (CB).

**Beats:**
- Accept: `in_valid && in_ready` at a rising edge.
- A beat is writable when fmt != 11 and it passes the range check (see Configuration).
- Writable beat: wr_en, wr_addr = count, and wr_data are registered at the accepting edge; count increments at that same edge.
- Non-writable beat: consumed, err set, no write, count unchanged.

**FSM:**
- S_IDLE (count = 0) -> S_FILL on first writable accept.
- S_FILL -> S_FULL when count reaches IMEM_DEPTH.
- Any state -> S_IDLE on flush.
- in_ready = state != S_FULL.

**Boundary conditions:**
- Flush with simultaneous accept: flush wins. The beat is dropped, wr_en = 0 next cycle, count = 0, err = 0.
- Last slot: the accept that makes count == IMEM_DEPTH still writes address IMEM_DEPTH-1. in_ready drops the following cycle.
- No wrap-around: addresses never return to 0 without flush or reset.

## Timing
- Reset (async, immediate): wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0, state=S_IDLE; in_ready=1 once reset_n is high.
- Latency: accept at edge t -> wr_en high for exactly one cycle after edge t; memory captures at edge t+1.
- Throughput: one beat per cycle, back-to-back, no bubbles.
- wr_en = 0 in any cycle following an edge with no writable accept.
- Reset asserted mid-write: wr_en falls immediately (asynchronously). No partial state survives.
- in_ready and full are derived from registered state only; no combinational path from in_valid.

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined:
  - Out-of-range immediates are non-writable and set err.
- Not defined:
  - Immediates are silently truncated to K bits and written.
  - err only flags fmt = 11.

## Structure
- `instr_encoder_pkg` holds:
  - fmt enum (`FMT_LDUR`, `FMT_STUR`, `FMT_CBZ`, `FMT_RSVD`).
  - Opcode constants `OP_LDUR` = 11'b11111000010, `OP_STUR` = 11'b11111000000, `OP_CBZ` = 8'b10110100.
  - Field widths `IMM_D_W` = 9, `IMM_CB_W` = 19.
- One combinational sub-module, `instr_pack`:
  - Inputs: fmt, rt, rn, imm.
  - Outputs: word[31:0], range_ok, fmt_ok.
  - Also instantiable next to signext for round-trip checking.
- Top level holds the FSM, count, and output registers.

## Test plan
- Reset, then LDUR rt=2 rn=1 imm=1 -> next cycle wr_en=1, wr_addr=0, wr_data=32'hF8401022, count=1.
- STUR rt=2 rn=1 imm=-2, then CBZ rt=2 imm=-3, back-to-back -> two consecutive write cycles: 32'hF81FE022 @0, 32'hB4FFFFA2 @1.
- LDUR rt=2 rn=1 imm=256:
  - With macro: no wr_en, err=1, count unchanged.
  - Without macro: wr_data=32'hF8500022.
- fmt=11 -> no write, err=1. A subsequent flush clears err and count.
- IMEM_DEPTH=4, in_valid held for 5 beats:
  - Writes to addresses 0-3, full=1, in_ready=0; the 5th beat is held.
  - flush -> count=0, in_ready=1 next cycle, and the 5th beat is written at address 0.
- reset_n pulsed low while wr_en=1 -> wr_en, count, and err all 0 immediately; next beat writes address 0.
